// File: rtl/countdown_pkg.sv
// Shared types for the countdown timer: FSM state and run-mode encodings.
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    EXPIRED
  } state_t;

  typedef enum logic {
    ONE_SHOT,
    PERIODIC
  } mode_t;

endpackage : countdown_pkg

// File: rtl/countdown_prescaler.sv
// Divides the clock into a one-cycle tick every PRESCALE enabled cycles.
// Only instantiated when COUNTDOWN_PRESCALER_EN is defined.
module countdown_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] r_cnt;

  assign tick = en && (r_cnt == LAST);

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= tick ? '0 : r_cnt + 1'b1;
    end
  end

endmodule : countdown_prescaler

// File: rtl/countdown_timer_n.sv
// WIDTH-bit countdown timer with start/pause, one-shot/periodic reload and a
// registered terminal-count pulse. Define COUNTDOWN_PRESCALER_EN to add a prescaler.
module countdown_timer_n
  import countdown_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] D,
  input  logic             start,
  input  logic             pause,
  input  logic             periodic,
  output logic [WIDTH-1:0] Q,
  output logic             done,
  output logic             busy,
  output logic             expired
);

  if (WIDTH < 2 || PRESCALE < 1) begin : g_param_check
    $error("countdown_timer_n: WIDTH must be >= 2 and PRESCALE >= 1");
  end

  state_t           r_state;
  mode_t            r_mode;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_reload;
  logic             r_done;
  logic             r_busy;
  logic             r_expired;

  state_t           w_state_nxt;
  mode_t            w_mode_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_reload_nxt;
  logic             w_done_nxt;
  logic             w_tick;

`ifdef COUNTDOWN_PRESCALER_EN
  logic w_presc_clear;
  logic w_presc_en;

  // Load and start both restart the tick phase; outside RUN the divider idles at 0.
  assign w_presc_clear = load || start || (r_state != RUN);
  assign w_presc_en    = (r_state == RUN) && !pause;

  countdown_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .clear (w_presc_clear),
    .en    (w_presc_en),
    .tick  (w_tick)
  );
`else
  assign w_tick = 1'b1;
`endif

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_mode_nxt   = r_mode;
    w_q_nxt      = r_q;
    w_reload_nxt = r_reload;
    w_done_nxt   = 1'b0;

    if (load) begin
      w_q_nxt      = D;
      w_reload_nxt = D;
      w_state_nxt  = IDLE;
    end else if (start) begin
      unique case (r_state)
        IDLE: begin
          if (r_q != '0) begin
            w_mode_nxt  = mode_t'(periodic);
            w_state_nxt = RUN;
          end
        end
        EXPIRED: begin
          if (r_reload != '0) begin
            w_q_nxt     = r_reload;
            w_mode_nxt  = mode_t'(periodic);
            w_state_nxt = RUN;
          end
        end
        default: begin
          w_q_nxt     = r_reload;
          w_mode_nxt  = mode_t'(periodic);
          w_state_nxt = RUN;
        end
      endcase
    end else begin
      unique case (r_state)
        RUN: begin
          if (pause) begin
            w_state_nxt = PAUSE;
          end else if (w_tick && (r_q != '0)) begin
            if (r_q == WIDTH'(1)) begin
              w_done_nxt = 1'b1;
              if (r_mode == PERIODIC) begin
                w_q_nxt = r_reload;
              end else begin
                w_q_nxt     = '0;
                w_state_nxt = EXPIRED;
              end
            end else begin
              w_q_nxt = r_q - 1'b1;
            end
          end
        end
        PAUSE: begin
          if (!pause) w_state_nxt = RUN;
        end
        default: ;
      endcase
    end
  end

  // Status flags are decoded from the next state so they move on the same edge as Q.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_mode    <= ONE_SHOT;
      r_q       <= '0;
      r_reload  <= '0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_mode    <= w_mode_nxt;
      r_q       <= w_q_nxt;
      r_reload  <= w_reload_nxt;
      r_done    <= w_done_nxt;
      r_busy    <= (w_state_nxt == RUN) || (w_state_nxt == PAUSE);
      r_expired <= (w_state_nxt == EXPIRED);
    end
  end

  assign Q       = r_q;
  assign done    = r_done;
  assign busy    = r_busy;
  assign expired = r_expired;

endmodule : countdown_timer_n

// File: tb/tb_countdown_timer_n.sv
// Self-checking bench for countdown_timer_n: directed scenarios plus random
// stimulus, all compared every cycle against a behavioural reference model.
module tb_countdown_timer_n;

  localparam int W = 4;
`ifdef COUNTDOWN_PRESCALER_EN
  localparam int PS = 3;
`else
  localparam int PS = 1;
`endif

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_EXP   = 3;

  logic         clk = 1'b0;
  logic         rst, load, start, pause, periodic;
  logic [W-1:0] D;
  logic [W-1:0] Q;
  logic         done, busy, expired;

  int total = 0;
  int bad   = 0;

  // Reference model: count value, reload value, mode, phase and cycle divider.
  int m_q   = 0;
  int m_rel = 0;
  int m_div = 0;
  int m_st  = M_IDLE;
  bit m_per = 1'b0;
  bit m_done = 1'b0;

  always #5 clk = ~clk;

  countdown_timer_n #(
    .WIDTH    (W),
    .PRESCALE (PS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .D        (D),
    .start    (start),
    .pause    (pause),
    .periodic (periodic),
    .Q        (Q),
    .done     (done),
    .busy     (busy),
    .expired  (expired)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock edge of the reference behaviour, using the inputs currently driven.
  task automatic model_edge();
    m_done = 1'b0;
    if (rst) begin
      m_q = 0; m_rel = 0; m_per = 1'b0; m_st = M_IDLE; m_div = 0;
    end else if (load) begin
      m_q = int'(D); m_rel = int'(D); m_st = M_IDLE; m_div = 0;
    end else if (start) begin
      if (m_st == M_IDLE) begin
        if (m_q != 0) begin
          m_per = periodic; m_st = M_RUN; m_div = 0;
        end
      end else if (m_st == M_EXP) begin
        if (m_rel != 0) begin
          m_q = m_rel; m_per = periodic; m_st = M_RUN; m_div = 0;
        end
      end else begin
        m_q = m_rel; m_per = periodic; m_st = M_RUN; m_div = 0;
      end
    end else if (m_st == M_RUN) begin
      if (pause) begin
        m_st = M_PAUSE; m_div = 0;
      end else begin
        m_div++;
        if (m_div == PS) begin
          m_div = 0;
          if (m_q == 1) begin
            m_done = 1'b1;
            if (m_per) m_q = m_rel;
            else begin
              m_q = 0; m_st = M_EXP;
            end
          end else begin
            m_q--;
          end
        end
      end
    end else if (m_st == M_PAUSE && !pause) begin
      m_st = M_RUN;
    end
  endtask

  task automatic cycle(input bit r, input bit l, input bit s, input bit p, input bit per,
                       input logic [W-1:0] d);
    rst = r; load = l; start = s; pause = p; periodic = per; D = d;
    @(posedge clk);
    model_edge();
    #1;
    check("q", Q, m_q);
    check("done", done, m_done);
    check("busy", busy, (m_st == M_RUN) || (m_st == M_PAUSE));
    check("expired", expired, m_st == M_EXP);
  endtask

  task automatic idle(input int n, input bit p);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, p, 1'b0, '0);
  endtask

  initial begin
    // Reset wins over a simultaneous load.
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd5);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd5);
    check("rst_q", Q, 0);
    check("rst_flags", {done, busy, expired}, 3'b000);
    idle(1, 1'b0);
    // Start with Q=0 from IDLE is ignored.
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    check("start_zero_busy", busy, 0);

    // One-shot from 8.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd8);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    check("os_start_q", Q, 8);
    for (int i = 1; i <= 8 * PS; i++) begin
      idle(1, 1'b0);
      if (i % PS == 0) check("os_seq", Q, 8 - i / PS);
    end
    check("os_done", done, 1);
    check("os_expired", {busy, expired}, 2'b01);
    idle(3, 1'b0);
    check("os_hold_q", Q, 0);
    check("os_done_clear", done, 0);

    // Periodic from 3: 3,2,1,3,2,1,3 with done on each return to 3.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, '0);
    check("per_start_q", Q, 3);
    for (int i = 1; i <= 6 * PS; i++) begin
      idle(1, 1'b0);
      if (i % PS == 0) begin
        check("per_seq", Q, 3 - ((i / PS) % 3));
        check("per_done", done, ((i / PS) % 3) == 0);
        check("per_busy", busy, 1);
      end
    end

    // Pause at Q=5 for 4 cycles; resume decrements one tick period after release.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd8);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    idle(3 * PS, 1'b0);
    check("pause_pre_q", Q, 5);
    for (int i = 0; i < 4; i++) begin
      idle(1, 1'b1);
      check("pause_hold_q", Q, 5);
    end
    for (int i = 1; i <= PS + 1; i++) begin
      idle(1, 1'b0);
      check("pause_resume_q", Q, (i == PS + 1) ? 4 : 5);
      check("pause_no_done", done, 0);
    end

    // Load overrides a simultaneous start while running at Q=4.
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd10);
    check("ld_q", Q, 10);
    check("ld_flags", {done, busy, expired}, 3'b000);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    idle(PS, 1'b0);
    check("ld_count_q", Q, 9);

    // One-shot from 4: single done exactly 4 tick periods after start.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd4);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    idle(4 * PS - 1, 1'b0);
    check("ps_pre_q", Q, 1);
    check("ps_pre_done", done, 0);
    idle(1, 1'b0);
    check("ps_zero_q", Q, 0);
    check("ps_done", done, 1);
    idle(1, 1'b0);
    check("ps_done_once", done, 0);

    // Reset mid-count clears everything including the reload value.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd6);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, '0);
    idle(2, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    check("midrst_q", Q, 0);
    check("midrst_busy", busy, 0);

    // Random stimulus against the model.
    for (int i = 0; i < 800; i++) begin
      cycle($urandom_range(63) == 0, $urandom_range(15) == 0, $urandom_range(9) == 0,
            $urandom_range(4) == 0, 1'($urandom_range(1)), W'($urandom_range(2**W - 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_countdown_timer_n
